// File: rtl/complex_int_div.sv
// complex_int_div: iterative complex divider z = a*conj(b)/|b|^2 using two
// restoring dividers sharing one denominator, one quotient bit per cycle.
module complex_int_div #(
    parameter int DW   = 16,
    parameter int FRAC = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a_re,
    input  logic [DW-1:0] a_im,
    input  logic [DW-1:0] b_re,
    input  logic [DW-1:0] b_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] z_re,
    output logic [DW-1:0] z_im,
    output logic          ovf,
    output logic          dz
);
    localparam int NI   = 2*DW + 1 + FRAC;
    localparam int DENW = 2*DW + 1;
    localparam int MW   = NI;
    localparam int CW   = $clog2(NI);
    localparam logic [DW-1:0] MAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MIN  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [MW-1:0] HALF = MW'(1) << (DW-1);

    typedef enum logic [2:0] {IDLE, MULT, DIV, SAT, DONE} state_t;

    state_t                 state_q, state_d;
    logic signed [DW-1:0]   a_re_q, a_im_q, b_re_q, b_im_q;
    logic signed [DW-1:0]   a_re_d, a_im_d, b_re_d, b_im_d;
    logic [DENW-1:0]        den_q, den_d, rem_re_q, rem_re_d, rem_im_q, rem_im_d;
    logic [MW-1:0]          num_re_q, num_re_d, num_im_q, num_im_d;
    logic                   neg_re_q, neg_re_d, neg_im_q, neg_im_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DW-1:0]          z_re_q, z_re_d, z_im_q, z_im_d;
    logic                   ovf_q, ovf_d, dz_q, dz_d;

    logic signed [DENW-1:0] p_re, p_im, p_den;
    logic [DENW-1:0]        mag_re, mag_im;
    logic [DENW:0]          sh_re, sh_im;
    logic                   ge_re, ge_im, of_re, of_im, den_zero;
    logic [DW-1:0]          s_re, s_im;

    // Positive quotients clip at MAX; negative ones may reach exactly MIN.
    function automatic logic [DW:0] sat(input logic [MW-1:0] q, input logic neg);
        return neg ? (q > HALF ? {1'b1, MIN} : {1'b0, DW'(-q)})
                   : (q > HALF - 1'b1 ? {1'b1, MAX} : {1'b0, DW'(q)});
    endfunction

    always_comb begin
        state_d  = state_q;
        a_re_d   = a_re_q;
        a_im_d   = a_im_q;
        b_re_d   = b_re_q;
        b_im_d   = b_im_q;
        den_d    = den_q;
        rem_re_d = rem_re_q;
        rem_im_d = rem_im_q;
        num_re_d = num_re_q;
        num_im_d = num_im_q;
        neg_re_d = neg_re_q;
        neg_im_d = neg_im_q;
        cnt_d    = cnt_q;
        z_re_d   = z_re_q;
        z_im_d   = z_im_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        p_re     = DENW'(a_re_q) * DENW'(b_re_q) + DENW'(a_im_q) * DENW'(b_im_q);
        p_im     = DENW'(a_im_q) * DENW'(b_re_q) - DENW'(a_re_q) * DENW'(b_im_q);
        p_den    = DENW'(b_re_q) * DENW'(b_re_q) + DENW'(b_im_q) * DENW'(b_im_q);
        mag_re   = p_re[DENW-1] ? -p_re : p_re;
        mag_im   = p_im[DENW-1] ? -p_im : p_im;
        sh_re    = {rem_re_q, num_re_q[MW-1]};
        sh_im    = {rem_im_q, num_im_q[MW-1]};
        ge_re    = sh_re >= {1'b0, den_q};
        ge_im    = sh_im >= {1'b0, den_q};
        den_zero = den_q == '0;
        {of_re, s_re} = sat(num_re_q, neg_re_q);
        {of_im, s_im} = sat(num_im_q, neg_im_q);
        unique case (state_q)
            IDLE: if (in_valid) begin
                a_re_d  = a_re;
                a_im_d  = a_im;
                b_re_d  = b_re;
                b_im_d  = b_im;
                state_d = MULT;
            end
            MULT: begin
                den_d    = p_den;
                neg_re_d = p_re[DENW-1];
                neg_im_d = p_im[DENW-1];
                num_re_d = MW'(mag_re) << FRAC;
                num_im_d = MW'(mag_im) << FRAC;
                rem_re_d = '0;
                rem_im_d = '0;
                cnt_d    = '0;
                state_d  = p_den == '0 ? SAT : DIV;
            end
            DIV: begin
                // Quotient bits shift in at the bottom as dividend bits leave the top.
                num_re_d = {num_re_q[MW-2:0], ge_re};
                num_im_d = {num_im_q[MW-2:0], ge_im};
                rem_re_d = ge_re ? DENW'(sh_re - {1'b0, den_q}) : sh_re[DENW-1:0];
                rem_im_d = ge_im ? DENW'(sh_im - {1'b0, den_q}) : sh_im[DENW-1:0];
                cnt_d    = cnt_q + 1'b1;
                state_d  = cnt_q == CW'(NI-1) ? SAT : DIV;
            end
            SAT: begin
                z_re_d  = den_zero ? '0 : s_re;
                z_im_d  = den_zero ? '0 : s_im;
                ovf_d   = !den_zero && (of_re || of_im);
                dz_d    = den_zero;
                state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_re_q   <= '0;
            a_im_q   <= '0;
            b_re_q   <= '0;
            b_im_q   <= '0;
            den_q    <= '0;
            rem_re_q <= '0;
            rem_im_q <= '0;
            num_re_q <= '0;
            num_im_q <= '0;
            neg_re_q <= 1'b0;
            neg_im_q <= 1'b0;
            cnt_q    <= '0;
            z_re_q   <= '0;
            z_im_q   <= '0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_re_q   <= a_re_d;
            a_im_q   <= a_im_d;
            b_re_q   <= b_re_d;
            b_im_q   <= b_im_d;
            den_q    <= den_d;
            rem_re_q <= rem_re_d;
            rem_im_q <= rem_im_d;
            num_re_q <= num_re_d;
            num_im_q <= num_im_d;
            neg_re_q <= neg_re_d;
            neg_im_q <= neg_im_d;
            cnt_q    <= cnt_d;
            z_re_q   <= z_re_d;
            z_im_q   <= z_im_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign z_re      = z_re_q;
    assign z_im      = z_im_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;
endmodule

// File: tb/tb_complex_int_div.sv
// tb_complex_int_div: directed checks of the complex divider at FRAC=0 and FRAC=8.
module tb_complex_int_div;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        iv0 = 1'b0, iv8 = 1'b0, out_ready = 1'b1;
    logic [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic        in_ready0, out_valid0, ovf0, dz0;
    logic        in_ready8, out_valid8, ovf8, dz8;
    logic [15:0] z_re0, z_im0, z_re8, z_im8;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    complex_int_div #(.DW(16), .FRAC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(in_ready0),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid0), .out_ready(out_ready),
        .z_re(z_re0), .z_im(z_im0), .ovf(ovf0), .dz(dz0));

    complex_int_div #(.DW(16), .FRAC(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(in_ready8),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid8), .out_ready(out_ready),
        .z_re(z_re8), .z_im(z_im8), .ovf(ovf8), .dz(dz8));

    // {out_valid, z_re, z_im, ovf, dz}
    function automatic logic [34:0] exp_res(input logic [15:0] zr, zi, input logic ov, d);
        return {1'b1, zr, zi, ov, d};
    endfunction

    function automatic logic [34:0] model(input logic signed [15:0] ar, ai, br, bi, input int frac);
        longint nr, ni, den, qr, qi;
        logic [15:0] zr, zi;
        logic orr, oi;
        nr  = longint'(ar) * longint'(br) + longint'(ai) * longint'(bi);
        ni  = longint'(ai) * longint'(br) - longint'(ar) * longint'(bi);
        den = longint'(br) * longint'(br) + longint'(bi) * longint'(bi);
        if (den == 0) return {1'b1, 16'h0, 16'h0, 1'b0, 1'b1};
        qr  = (nr * (longint'(1) << frac)) / den;
        qi  = (ni * (longint'(1) << frac)) / den;
        orr = qr > 32767 || qr < -32768;
        oi  = qi > 32767 || qi < -32768;
        zr  = qr > 32767 ? 16'h7fff : qr < -32768 ? 16'h8000 : qr[15:0];
        zi  = qi > 32767 ? 16'h7fff : qi < -32768 ? 16'h8000 : qi[15:0];
        return {1'b1, zr, zi, orr | oi, 1'b0};
    endfunction

    // Issues one operation and waits (bounded) for its result.
    task automatic run_op(input bit sel, input logic [15:0] ar, ai, br, bi,
                          output logic [34:0] res, output int lat);
        @(negedge clk);
        a_re = ar; a_im = ai; b_re = br; b_im = bi;
        if (sel) iv8 = 1'b1; else iv0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv0 = 1'b0; iv8 = 1'b0;
        lat = 0;
        while (!(sel ? out_valid8 : out_valid0) && lat < 200) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        res = sel ? {out_valid8, z_re8, z_im8, ovf8, dz8} : {out_valid0, z_re0, z_im0, ovf0, dz0};
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({in_ready0, out_valid0, z_re0, z_im0, ovf0, dz0} !== {1'b1, 1'b0, 32'h0, 2'b0}) begin
            errors++; $display("FAIL reset0: got %h exp %h", {in_ready0, out_valid0, z_re0, z_im0, ovf0, dz0}, {1'b1, 1'b0, 32'h0, 2'b0});
        end
        checks++;
        if ({in_ready8, out_valid8, z_re8, z_im8, ovf8, dz8} !== {1'b1, 1'b0, 32'h0, 2'b0}) begin
            errors++; $display("FAIL reset8: got %h exp %h", {in_ready8, out_valid8, z_re8, z_im8, ovf8, dz8}, {1'b1, 1'b0, 32'h0, 2'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [34:0] r;
        int lat;
        run_op(0, 16'd6, 16'd8, 16'd3, 16'd4, r, lat);
        checks++;
        if (r !== exp_res(16'd2, 16'd0, 0, 0)) begin errors++; $display("FAIL basic_6p8j: got %h exp %h", r, exp_res(16'd2, 16'd0, 0, 0)); end
        checks++;
        if (lat !== 35) begin errors++; $display("FAIL basic_latency: got %0d exp 35", lat); end
        run_op(0, 16'd1, 16'd0, 16'd0, 16'd1, r, lat);
        checks++;
        if (r !== exp_res(16'd0, 16'hffff, 0, 0)) begin errors++; $display("FAIL div_by_j: got %h exp %h", r, exp_res(16'd0, 16'hffff, 0, 0)); end
    endtask

    task automatic test_trunc();
        logic [34:0] r;
        int lat;
        run_op(0, 16'd7, 16'd0, 16'd2, 16'd0, r, lat);
        checks++;
        if (r !== exp_res(16'd3, 16'd0, 0, 0)) begin errors++; $display("FAIL trunc_pos: got %h exp %h", r, exp_res(16'd3, 16'd0, 0, 0)); end
        run_op(0, 16'hfff9, 16'd0, 16'd2, 16'd0, r, lat);
        checks++;
        if (r !== exp_res(16'hfffd, 16'd0, 0, 0)) begin errors++; $display("FAIL trunc_neg: got %h exp %h", r, exp_res(16'hfffd, 16'd0, 0, 0)); end
    endtask

    task automatic test_sat_dz();
        logic [34:0] r;
        int lat;
        run_op(0, 16'h8000, 16'd0, 16'hffff, 16'd0, r, lat);
        checks++;
        if (r !== exp_res(16'h7fff, 16'd0, 1, 0)) begin errors++; $display("FAIL sat_max: got %h exp %h", r, exp_res(16'h7fff, 16'd0, 1, 0)); end
        run_op(0, 16'h8000, 16'd0, 16'd1, 16'd0, r, lat);
        checks++;
        if (r !== exp_res(16'h8000, 16'd0, 0, 0)) begin errors++; $display("FAIL exact_min: got %h exp %h", r, exp_res(16'h8000, 16'd0, 0, 0)); end
        run_op(0, 16'd5, 16'd5, 16'd0, 16'd0, r, lat);
        checks++;
        if (r !== exp_res(16'd0, 16'd0, 0, 1)) begin errors++; $display("FAIL div_zero: got %h exp %h", r, exp_res(16'd0, 16'd0, 0, 1)); end
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL dz_latency: got %0d exp 2", lat); end
    endtask

    task automatic test_frac();
        logic [34:0] r;
        int lat;
        run_op(1, 16'd1, 16'd0, 16'd3, 16'd0, r, lat);
        checks++;
        if (r !== exp_res(16'd85, 16'd0, 0, 0)) begin errors++; $display("FAIL frac_third: got %h exp %h", r, exp_res(16'd85, 16'd0, 0, 0)); end
        checks++;
        if (lat !== 43) begin errors++; $display("FAIL frac_latency: got %0d exp 43", lat); end
        run_op(1, 16'd1, 16'd1, 16'd2, 16'd0, r, lat);
        checks++;
        if (r !== exp_res(16'd128, 16'd128, 0, 0)) begin errors++; $display("FAIL frac_half: got %h exp %h", r, exp_res(16'd128, 16'd128, 0, 0)); end
        run_op(1, 16'hff38, 16'd0, 16'd1, 16'd0, r, lat);
        checks++;
        if (r !== exp_res(16'h8000, 16'd0, 1, 0)) begin errors++; $display("FAIL sat_min: got %h exp %h", r, exp_res(16'h8000, 16'd0, 1, 0)); end
    endtask

    task automatic test_backpressure();
        logic [34:0] r;
        int lat;
        out_ready = 1'b0;
        run_op(0, 16'd6, 16'd8, 16'd3, 16'd4, r, lat);
        checks++;
        if (r !== exp_res(16'd2, 16'd0, 0, 0)) begin errors++; $display("FAIL bp_first: got %h exp %h", r, exp_res(16'd2, 16'd0, 0, 0)); end
        a_re = 16'd7; a_im = 16'd0; b_re = 16'd2; b_im = 16'd0; iv0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if ({out_valid0, in_ready0, z_re0, z_im0, ovf0, dz0} !== {2'b10, 16'd2, 16'd0, 2'b00}) begin
                errors++; $display("FAIL bp_hold%0d: got %h exp %h", i, {out_valid0, in_ready0, z_re0, z_im0, ovf0, dz0}, {2'b10, 16'd2, 16'd0, 2'b00});
            end
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({out_valid0, in_ready0, z_re0} !== {2'b01, 16'd2}) begin
            errors++; $display("FAIL bp_release: got %h exp %h", {out_valid0, in_ready0, z_re0}, {2'b01, 16'd2});
        end
        @(posedge clk); @(negedge clk);
        iv0 = 1'b0;
        checks++;
        if (in_ready0 !== 1'b0) begin errors++; $display("FAIL bp_accept: got %b exp 0", in_ready0); end
        lat = 0;
        while (!out_valid0 && lat < 200) begin @(posedge clk); lat++; @(negedge clk); end
        checks++;
        if ({lat, out_valid0, z_re0, z_im0, ovf0, dz0} !== {32'd35, exp_res(16'd3, 16'd0, 0, 0)}) begin
            errors++; $display("FAIL bp_second: got lat=%0d %h exp lat=35 %h", lat, {out_valid0, z_re0, z_im0, ovf0, dz0}, exp_res(16'd3, 16'd0, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        logic [34:0] r, e;
        logic [15:0] ar, ai, br, bi;
        int lat;
        for (int i = 0; i < 10; i++) begin
            ar = 16'($urandom); ai = 16'($urandom);
            br = (i < 5) ? 16'($urandom_range(0, 40)) - 16'd20 : 16'($urandom);
            bi = (i < 5) ? 16'($urandom_range(0, 40)) - 16'd20 : 16'($urandom);
            e = model(ar, ai, br, bi, 0);
            run_op(0, ar, ai, br, bi, r, lat);
            checks++;
            if (r !== e) begin errors++; $display("FAIL b2b%0d: a=%h+%hj b=%h+%hj got %h exp %h", i, ar, ai, br, bi, r, e); end
            checks++;
            if (lat !== (e[0] ? 2 : 35)) begin errors++; $display("FAIL b2b_lat%0d: got %0d exp %0d", i, lat, e[0] ? 2 : 35); end
        end
    endtask

    task automatic test_reset_mid();
        logic [34:0] r;
        int lat, seen;
        @(negedge clk);
        a_re = 16'd7; a_im = 16'd0; b_re = 16'd2; b_im = 16'd0; iv0 = 1'b1;
        @(posedge clk); @(negedge clk);
        iv0 = 1'b0;
        repeat (11) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready0, out_valid0, z_re0, z_im0, ovf0, dz0} !== {1'b1, 1'b0, 32'h0, 2'b0}) begin
            errors++; $display("FAIL mid_reset: got %h exp %h", {in_ready0, out_valid0, z_re0, z_im0, ovf0, dz0}, {1'b1, 1'b0, 32'h0, 2'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin @(posedge clk); @(negedge clk); if (out_valid0) seen++; end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL stale_result: got %0d exp 0", seen); end
        run_op(0, 16'd6, 16'd8, 16'd3, 16'd4, r, lat);
        checks++;
        if ({lat, r} !== {32'd35, exp_res(16'd2, 16'd0, 0, 0)}) begin
            errors++; $display("FAIL post_reset: got lat=%0d %h exp lat=35 %h", lat, r, exp_res(16'd2, 16'd0, 0, 0));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_trunc();
        test_sat_dz();
        test_frac();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/complex_int_div.md
Name: complex_int_div

Overview:
- Iterative complex integer divider, z = a / b. Inverse operation of the pipelined complex multiplier.
- Used in the window-function path to remove a window or gain from complex samples (de-windowing, equalisation).
- Computes a*conj(b) / |b|^2 using two shared-denominator restoring dividers, one quotient bit per cycle.
- Valid/ready handshake on both sides. One operation in flight at a time.

Parameters:
- DW, 16: width of each signed component (re, im) of a, b and z.
- FRAC, 0: fractional bits of the quotient. Result is (num << FRAC) / den.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  a/b operands valid
- in_ready  out  1  block can accept operands
- a_re, a_im  in  DW  signed dividend
- b_re, b_im  in  DW  signed divisor
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- z_re, z_im  out  DW  signed quotient
- ovf  out  1  z_re and/or z_im saturated; qualified by out_valid
- dz  out  1  divide by zero (b = 0); qualified by out_valid

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - Outputs: in_ready=1, out_valid=0, z_re=z_im=0, ovf=0, dz=0.
  - All internal registers cleared.
  - Reset mid-operation aborts the operation; no result is produced.
- Constant: NI = 2*DW+1+FRAC (number of division iterations).
- IDLE:
  - in_ready=1.
  - When in_valid && in_ready: register a and b, go to MULT.
- MULT (1 cycle), all arithmetic full precision and signed:
  - num_re = a_re*b_re + a_im*b_im
  - num_im = a_im*b_re - a_re*b_im
  - den = b_re^2 + b_im^2 (unsigned, 2*DW+1 bits)
  - Store the sign of each numerator and its magnitude shifted left by FRAC.
  - Clear iteration counter. Go to DIV.
- DIV (NI cycles):
  - Each cycle, both dividers perform one restoring step on their magnitude (MSB first) against the shared den.
  - Counter counts 0..NI-1. On the last step go to SAT.
  - If den==0, skip DIV and go directly to SAT.
- SAT (1 cycle):
  - Apply the sign to each magnitude quotient. Rounding is truncation toward zero.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1]:
    - positive magnitude > 2^(DW-1)-1 -> max;
    - negative magnitude > 2^(DW-1) -> min.
  - ovf = saturation occurred on either component.
  - If den==0: z_re=z_im=0, dz=1, ovf=0.
  - Load output registers, out_valid=1, go to DONE.
- DONE:
  - Outputs are held stable while out_valid && !out_ready.
  - On out_ready: out_valid=0, go to IDLE. z/ovf/dz keep their last values.
- in_ready is 1 only in IDLE. There is no accept in the same cycle as output release; the next accept happens in IDLE.
- Latency: operands accepted at edge N -> out_valid high after edge N+NI+2 (35 cycles at DW=16, FRAC=0). For den==0: N+2.
- Throughput: one result per NI+4 cycles with out_ready held high.
- in_valid in any state other than IDLE is ignored (not consumed).
- Inputs are sampled only at the accept edge. Operand changes afterwards have no effect.

Test Plan:
- a=6+8j, b=3+4j (DW=16, FRAC=0) -> z=2+0j, ovf=0, dz=0; out_valid exactly 35 cycles after accept.
- a=1+0j, b=0+1j -> z=0-1j. Then a=7+0j, b=2+0j -> z=3+0j; a=-7+0j, b=2+0j -> z=-3+0j (truncation toward zero).
- a=-32768+0j, b=-1+0j -> z=32767+0j, ovf=1. Also a=5+5j, b=0+0j -> z=0+0j, dz=1, out_valid 2 cycles after accept.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> z/ovf/dz stable, in_ready=0, a new in_valid is not accepted. Release -> next accept occurs in IDLE. Back-to-back 10 random operations checked against a reference model (a*conj(b))/|b|^2 with truncation and saturation.
- FRAC=8, a=1+0j, b=3+0j -> z_re=85 (256/3 truncated). FRAC=8, a=1+1j, b=2+0j -> z=128+128j.
- Assert rst_n low mid-DIV (iteration 10) -> all outputs 0, in_ready=1 immediately. After release, a new operation a=6+8j, b=3+4j completes correctly with no stale result.
